// File: rtl/regbank_pkg.sv
// regbank_pkg: shared definitions for the banked register file.
//   - clr_state_e  : background bank-clear sequencer states
//   - DEF_*        : default sizing constants
//   - ctx_width()  : bank-select width, never less than one bit
package regbank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_CTX  = 2;
  localparam int DEF_LINK_REG = 30;

  function automatic int ctx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regbank_clear_fsm.sv
// regbank_clear_fsm: background sequencer that zeroes one bank, one entry per
// clock, for context teardown.
// Ports:
//   Clock, Reset_n  : clock, asynchronous active-low reset
//   ClearReq        : start request, only honoured in IDLE with a valid bank
//   ClearCtx        : bank to clear (latched on acceptance)
//   CtxWrite        : bank targeted by the current write/jal
//   ClearBusy       : sequencer sweeping (CLEAR)
//   ClearDone       : one-cycle completion pulse (DONE)
//   clr_en          : zero entry clr_idx of bank clr_ctx on this edge
//   clr_ctx/clr_idx : bank and entry being swept
//   wr_block        : current write/jal targets the bank being swept; drop it
module regbank_clear_fsm
  import regbank_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_CTX = DEF_NUM_CTX,
  parameter int CTX_W   = ctx_width(NUM_CTX)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ClearReq,
  input  logic [CTX_W-1:0]  ClearCtx,
  input  logic [CTX_W-1:0]  CtxWrite,
  output logic              ClearBusy,
  output logic              ClearDone,
  output logic              clr_en,
  output logic [CTX_W-1:0]  clr_ctx,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              wr_block
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CTX_W-1:0]  ctx_q, ctx_d;
  logic              req_ok;

  // A request naming a nonexistent bank is not started at all.
  assign req_ok = ClearReq && ({1'b0, ClearCtx} < (CTX_W+1)'(NUM_CTX));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ctx_q   <= ctx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ctx_d   = ctx_q;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d = CLEAR;
          ctx_d   = ClearCtx;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ClearBusy = (state_q == CLEAR);
  assign ClearDone = (state_q == DONE);
  assign clr_en    = (state_q == CLEAR);
  assign clr_ctx   = ctx_q;
  assign clr_idx   = ptr_q;
  assign wr_block  = (state_q == CLEAR) && (CtxWrite == ctx_q);

endmodule

// File: rtl/banked_register_file.sv
// banked_register_file: NUM_CTX banks of 2^ADDR_W x DATA_W registers with
// three combinational read ports, one write port, a jal link write
// (ProgramCounter+1 into LINK_REG) and a background bank-clear sequencer.
// Optional macro REGBANK_BYPASS_EN: same-cycle forwarding of the pending
// write (or jal link value) to reads of the same bank and register.
// Ports:
//   Clock, Reset_n            : clock, asynchronous active-low reset
//   CtxRead, Addr1..3         : read bank and addresses
//   Data1..3                  : read data (0 for a nonexistent bank)
//   CtxWrite, Write,
//   AddrWrite, DataIn         : write port
//   jal, ProgramCounter       : link-register write
//   ClearReq, ClearCtx        : bank clear request
//   ClearBusy, ClearDone      : clear status
module banked_register_file
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_CTX  = DEF_NUM_CTX,
  parameter int LINK_REG = DEF_LINK_REG,
  parameter int CTX_W    = ctx_width(NUM_CTX)
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [CTX_W-1:0]  CtxRead,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [ADDR_W-1:0] Addr2,
  input  logic [ADDR_W-1:0] Addr3,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic [DATA_W-1:0] Data3,
  input  logic [CTX_W-1:0]  CtxWrite,
  input  logic              Write,
  input  logic [ADDR_W-1:0] AddrWrite,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              jal,
  input  logic [DATA_W-1:0] ProgramCounter,
  input  logic              ClearReq,
  input  logic [CTX_W-1:0]  ClearCtx,
  output logic              ClearBusy,
  output logic              ClearDone
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] mem [NUM_CTX][DEPTH];

  logic              clr_en;
  logic [CTX_W-1:0]  clr_ctx;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_block;
  logic              rd_ctx_ok, wr_ctx_ok;
  logic              wr_ok, jal_ok;
  logic [DATA_W-1:0] link_val;
  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];

  regbank_clear_fsm #(
    .ADDR_W  (ADDR_W),
    .NUM_CTX (NUM_CTX),
    .CTX_W   (CTX_W)
  ) u_clear (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .ClearReq  (ClearReq),
    .ClearCtx  (ClearCtx),
    .CtxWrite  (CtxWrite),
    .ClearBusy (ClearBusy),
    .ClearDone (ClearDone),
    .clr_en    (clr_en),
    .clr_ctx   (clr_ctx),
    .clr_idx   (clr_idx),
    .wr_block  (wr_block)
  );

  assign rd_ctx_ok = ({1'b0, CtxRead}  < (CTX_W+1)'(NUM_CTX));
  assign wr_ctx_ok = ({1'b0, CtxWrite} < (CTX_W+1)'(NUM_CTX));
  assign wr_ok     = Write && wr_ctx_ok && !wr_block;
  assign jal_ok    = jal   && wr_ctx_ok && !wr_block;
  // Wraps to zero for an all-ones PC.
  assign link_val  = ProgramCounter + {{(DATA_W-1){1'b0}}, 1'b1};

  // Later assignments win: Write overrides jal on the link register. The
  // sweep never collides with a write because writes to its bank are blocked.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int c = 0; c < NUM_CTX; c++)
        for (int a = 0; a < DEPTH; a++)
          mem[c][a] <= '0;
    end else begin
      if (jal_ok) mem[CtxWrite][LINK_A]    <= link_val;
      if (wr_ok)  mem[CtxWrite][AddrWrite] <= DataIn;
      if (clr_en) mem[clr_ctx][clr_idx]    <= '0;
    end
  end

  assign rd_addr[0] = Addr1;
  assign rd_addr[1] = Addr2;
  assign rd_addr[2] = Addr3;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = '0;
      if (rd_ctx_ok) begin
        rd_data[p] = mem[CtxRead][rd_addr[p]];
`ifdef REGBANK_BYPASS_EN
        // wr_ok/jal_ok already exclude writes dropped by an active clear.
        if (CtxRead == CtxWrite) begin
          if (wr_ok && (rd_addr[p] == AddrWrite))
            rd_data[p] = DataIn;
          else if (jal_ok && (rd_addr[p] == LINK_A))
            rd_data[p] = link_val;
        end
`endif
      end
    end
  end

  assign Data1 = rd_data[0];
  assign Data2 = rd_data[1];
  assign Data3 = rd_data[2];

endmodule

// File: tb/tb_banked_register_file.sv
module tb_banked_register_file;

  logic        Clock;
  logic        Reset_n;
  logic [0:0]  CtxRead;
  logic [4:0]  Addr1, Addr2, Addr3;
  logic [31:0] Data1, Data2, Data3;
  logic [0:0]  CtxWrite;
  logic        Write;
  logic [4:0]  AddrWrite;
  logic [31:0] DataIn;
  logic        jal;
  logic [31:0] ProgramCounter;
  logic        ClearReq;
  logic [0:0]  ClearCtx;
  logic        ClearBusy;
  logic        ClearDone;

  int n_cmp = 0;
  int n_bad = 0;

  banked_register_file dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .CtxRead        (CtxRead),
    .Addr1          (Addr1),
    .Addr2          (Addr2),
    .Addr3          (Addr3),
    .Data1          (Data1),
    .Data2          (Data2),
    .Data3          (Data3),
    .CtxWrite       (CtxWrite),
    .Write          (Write),
    .AddrWrite      (AddrWrite),
    .DataIn         (DataIn),
    .jal            (jal),
    .ProgramCounter (ProgramCounter),
    .ClearReq       (ClearReq),
    .ClearCtx       (ClearCtx),
    .ClearBusy      (ClearBusy),
    .ClearDone      (ClearDone)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic        wr;
    logic [0:0]  ctxw;
    logic [4:0]  aw;
    logic [31:0] din;
    logic        jl;
    logic [31:0] pc;
    logic [0:0]  ctxr;
    logic [4:0]  ar;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [0:0] c, input logic [4:0] a, input logic [31:0] d);
    CtxWrite = c; AddrWrite = a; DataIn = d; Write = 1'b1;
    step();
    Write = 1'b0;
  endtask

  task automatic read3(input string nm, input logic [0:0] c, input logic [4:0] a,
                       input logic [31:0] exp);
    CtxRead = c; Addr1 = a; Addr2 = a; Addr3 = a;
    #1;
    check({nm, ".d1"}, Data1, exp);
    check({nm, ".d2"}, Data2, exp);
    check({nm, ".d3"}, Data3, exp);
  endtask

  int busy_cnt, done_cnt, done_t;
  logic seen;

  initial begin
    vecs[0]  = '{"w_c0r5",     1, 0,  5, 32'hDEADBEEF, 0, 32'h0,        0,  5, 32'hDEADBEEF};
    vecs[1]  = '{"w_c1r5",     1, 1,  5, 32'h12345678, 0, 32'h0,        1,  5, 32'h12345678};
    vecs[2]  = '{"rd_c0r5",    0, 0,  0, 32'h0,        0, 32'h0,        0,  5, 32'hDEADBEEF};
    vecs[3]  = '{"wr_beats_jal",1,1, 30, 32'hAAAA0000, 1, 32'h00000010, 1, 30, 32'hAAAA0000};
    vecs[4]  = '{"jal_wrap",   0, 1,  0, 32'h0,        1, 32'hFFFFFFFF, 1, 30, 32'h00000000};
    vecs[5]  = '{"jal_c0",     0, 0,  0, 32'h0,        1, 32'h00000010, 0, 30, 32'h00000011};
    vecs[6]  = '{"c1r30_keep", 0, 0,  0, 32'h0,        0, 32'h0,        1, 30, 32'h00000000};
    vecs[7]  = '{"w_c0r0",     1, 0,  0, 32'h00000001, 0, 32'h0,        0,  0, 32'h00000001};
    vecs[8]  = '{"w_c0r31",    1, 0, 31, 32'hFFFFFFFF, 0, 32'h0,        0, 31, 32'hFFFFFFFF};
    vecs[9]  = '{"jal_plus_wr",1, 0,  7, 32'h00000077, 1, 32'h00000020, 0, 30, 32'h00000021};
    vecs[10] = '{"rd_c0r7",    0, 0,  0, 32'h0,        0, 32'h0,        0,  7, 32'h00000077};

    Reset_n = 1'b0; CtxRead = '0; Addr1 = '0; Addr2 = '0; Addr3 = '0;
    CtxWrite = '0; Write = 1'b0; AddrWrite = '0; DataIn = '0; jal = 1'b0;
    ProgramCounter = '0; ClearReq = 1'b0; ClearCtx = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    step();

    // Reset state
    check("rst_busy", {31'b0, ClearBusy}, 32'd0);
    check("rst_done", {31'b0, ClearDone}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 32; a++) begin
        CtxRead = c[0:0]; Addr1 = a[4:0]; Addr2 = 5'(31 - a); Addr3 = a[4:0] ^ 5'd5;
        #1;
        check("rst_d1", Data1, 32'd0);
        check("rst_d2", Data2, 32'd0);
        check("rst_d3", Data3, 32'd0);
      end
    end

    // Table-driven write / jal vectors
    for (int i = 0; i < 11; i++) begin
      CtxWrite = vecs[i].ctxw; Write = vecs[i].wr; AddrWrite = vecs[i].aw;
      DataIn = vecs[i].din; jal = vecs[i].jl; ProgramCounter = vecs[i].pc;
      step();
      Write = 1'b0; jal = 1'b0;
      read3(vecs[i].name, vecs[i].ctxr, vecs[i].ar, vecs[i].exp);
    end

    // Same-cycle read of a register being written
    wr(0, 3, 32'h33);
    CtxWrite = 0; AddrWrite = 3; DataIn = 32'h55; Write = 1'b1;
    CtxRead = 0; Addr1 = 3;
    #1;
`ifdef REGBANK_BYPASS_EN
    check("bypass_same_cycle", Data1, 32'h55);
`else
    check("no_bypass_same_cycle", Data1, 32'h33);
`endif
    step();
    Write = 1'b0;
    #1;
    check("write_next_cycle", Data1, 32'h55);

    // Fill both banks with distinct nonzero data
    for (int a = 0; a < 32; a++) wr(0, a[4:0], 32'hC0000000 | a);
    for (int a = 0; a < 32; a++) wr(1, a[4:0], 32'hA0000000 | a);

    // Clear bank 1 with mid-clear traffic and a redundant request
    ClearReq = 1'b1; ClearCtx = 1;
    step();
    ClearReq = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_t = -1;
    for (int t = 0; t < 40; t++) begin
      Write = 1'b0; ClearReq = 1'b0; ClearCtx = 0;
      if (t == 5) begin CtxWrite = 1; AddrWrite = 31; DataIn = 32'h00000BAD; Write = 1'b1; end
      if (t == 6) begin CtxWrite = 1; AddrWrite = 2;  DataIn = 32'h0000BAD2; Write = 1'b1; end
      if (t == 7) begin CtxWrite = 0; AddrWrite = 4;  DataIn = 32'h00004444; Write = 1'b1; end
      if (t == 9) ClearReq = 1'b1;
      #1;
      if (ClearBusy) busy_cnt++;
      if (ClearDone) begin done_cnt++; done_t = t; end
      step();
    end
    Write = 1'b0; ClearReq = 1'b0;
    check("clr_busy_cycles", busy_cnt, 32'd32);
    check("clr_done_pulses", done_cnt, 32'd1);
    check("clr_done_time", done_t, 32'd32);
    check("clr_idle_busy", {31'b0, ClearBusy}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      CtxRead = 1; Addr1 = a[4:0]; Addr2 = a[4:0]; Addr3 = a[4:0];
      #1;
      check("clr_c1_zero", Data1, 32'd0);
      CtxRead = 0;
      #1;
      check("clr_c0_kept", Data1, (a == 4) ? 32'h00004444 : (32'hC0000000 | a));
    end

    // Reset in the middle of a sweep
    wr(0, 9, 32'h99);
    ClearReq = 1'b1; ClearCtx = 1;
    step();
    ClearReq = 1'b0;
    repeat (10) step();
    check("pre_rst_busy", {31'b0, ClearBusy}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, ClearBusy}, 32'd0);
    check("midrst_done", {31'b0, ClearDone}, 32'd0);
    read3("midrst_c0r9", 0, 9, 32'd0);
    read3("midrst_c1r20", 1, 20, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    ClearReq = 1'b1; ClearCtx = 0;
    step();
    ClearReq = 1'b0;
    check("reclr_busy", {31'b0, ClearBusy}, 32'd1);
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      if (ClearDone) seen = 1'b1;
      else step();
    end
    check("reclr_done_seen", {31'b0, seen}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
